// File: rtl/accum_seq_pkg.sv
// Shared types and constants for the multicycle add/subtract accumulator.
package accum_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/accum_alu.sv
// Single add/subtract step at WIDTH+1 bits. It produces the carry/borrow and
// signed-overflow events and applies optional unsigned saturation.
module accum_alu
    import accum_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             sat_en,
    output logic [WIDTH-1:0] y,
    output logic             carry_evt,
    output logic             ovf_evt
);

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [WIDTH-1:0] raw;

    // Compute the raw result and events. Overflow is judged on the
    // unsaturated result, so the flag is set even when the output is clamped.
    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        dif_ext   = {1'b0, a} - {1'b0, b};
        raw       = '0;
        carry_evt = 1'b0;
        ovf_evt   = 1'b0;
        y         = '0;
        unique case (op)
            OP_ADD: begin
                raw       = sum_ext[WIDTH-1:0];
                carry_evt = sum_ext[WIDTH];
                ovf_evt   = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
                y         = (sat_en && carry_evt) ? '1 : raw;
            end
            OP_SUB: begin
                raw       = dif_ext[WIDTH-1:0];
                // The top bit of the extended difference is set exactly when a < b.
                carry_evt = dif_ext[WIDTH];
                ovf_evt   = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
                y         = (sat_en && carry_evt) ? '0 : raw;
            end
            default: begin
                raw = '0;
                y   = '0;
            end
        endcase
    end

endmodule

// File: rtl/accum_seq.sv
// Sequencer: latches NUM_OPS operands on start and loads operand 0 into the
// accumulator. It then applies one add or subtract per cycle, keeps sticky
// carry/overflow flags and pulses done when the result is final.
module accum_seq
    import accum_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_OPS*WIDTH-1:0] operands,
    input  logic [NUM_OPS-1:0]       op_mask,
    input  logic                     sat_en,
    output logic [WIDTH-1:0]         result,
    output logic                     busy,
    output logic                     done,
    output logic                     carry,
    output logic                     ovf
);

    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         acc_q, acc_d;
    logic [NUM_OPS*WIDTH-1:0] ops_q, ops_d;
    logic [NUM_OPS-1:0]       mask_q, mask_d;
    logic                     sat_q, sat_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     carry_q, carry_d;
    logic                     ovf_q, ovf_d;

    logic [WIDTH-1:0]         cur_b;
    logic                     cur_op;
    logic [WIDTH-1:0]         alu_y;
    logic                     alu_carry;
    logic                     alu_ovf;

    // Select the operand and operation for the current step. Slot 0 is only
    // a default selection because operand 0 is loaded directly at start.
    always_comb begin
        cur_b  = ops_q[WIDTH-1:0];
        cur_op = mask_q[0];
        for (int i = 1; i < NUM_OPS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_b  = ops_q[i*WIDTH +: WIDTH];
                cur_op = mask_q[i];
            end
        end
    end

    accum_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a         (acc_q),
        .b         (cur_b),
        .op        (cur_op),
        .sat_en    (sat_q),
        .y         (alu_y),
        .carry_evt (alu_carry),
        .ovf_evt   (alu_ovf)
    );

    // Next-state logic: capture on start, one step per ACCUM cycle, single DONE cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ops_d   = ops_q;
        mask_d  = mask_q;
        sat_d   = sat_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = operands[WIDTH-1:0];
                    ops_d   = operands;
                    mask_d  = op_mask;
                    sat_d   = sat_en;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    idx_d   = IDX_W'(1);
                    state_d = (NUM_OPS == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                acc_d   = alu_y;
                carry_d = carry_q | alu_carry;
                ovf_d   = ovf_q | alu_ovf;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_OPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                idx_d   = IDX_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset overrides start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ops_q   <= '0;
            mask_q  <= '0;
            sat_q   <= 1'b0;
            idx_q   <= IDX_W'(1);
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ops_q   <= ops_d;
            mask_q  <= mask_d;
            sat_q   <= sat_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign result = acc_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign carry  = carry_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_accum_seq.sv
// Bench for accum_seq: an arithmetic reference model per instance, a per-cycle
// compare, directed literal cases and a randomized phase.
module tb_accum_seq;

    localparam int WIDTH   = 8;
    localparam int NUM_OPS = 4;
    localparam int MAXV    = (1 << WIDTH) - 1;
    localparam int HALF    = 1 << (WIDTH - 1);

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic [NUM_OPS*WIDTH-1:0] operands;
    logic [NUM_OPS-1:0]       op_mask;
    logic                     sat_en;
    logic [WIDTH-1:0]         result;
    logic                     busy, done, carry, ovf;

    logic                     start1;
    logic [WIDTH-1:0]         operands1;
    logic                     op_mask1;
    logic                     sat_en1;
    logic [WIDTH-1:0]         result1;
    logic                     busy1, done1, carry1, ovf1;

    typedef struct {
        int res;
        bit busy;
        bit done;
        bit carry;
        bit ovf;
    } exp_t;

    exp_t cur0;
    exp_t cur1;
    exp_t q0[$];

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    accum_seq #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
        .clk(clk), .reset(reset), .start(start), .operands(operands),
        .op_mask(op_mask), .sat_en(sat_en), .result(result), .busy(busy),
        .done(done), .carry(carry), .ovf(ovf)
    );

    accum_seq #(.WIDTH(WIDTH), .NUM_OPS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .operands(operands1),
        .op_mask(op_mask1), .sat_en(sat_en1), .result(result1), .busy(busy1),
        .done(done1), .carry(carry1), .ovf(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - (MAXV + 1) : x;
    endfunction

    // Reference model for the 4-operand instance. On an accepted start the
    // whole sequence of per-cycle outputs is computed with plain integers.
    int acc_m, b_m, s_m, ss_m;
    bit c_m, o_m;
    always @(posedge clk) begin
        if (reset) begin
            q0.delete();
            cur0 = '{default: 0};
        end else if (!cur0.busy && start) begin
            acc_m = int'(operands[WIDTH-1:0]);
            c_m   = 1'b0;
            o_m   = 1'b0;
            q0.delete();
            for (int k = 0; k < NUM_OPS; k++) begin
                if (k > 0) begin
                    b_m = int'(operands[k*WIDTH +: WIDTH]);
                    if (op_mask[k]) begin
                        s_m  = acc_m + b_m;
                        ss_m = sgn(acc_m) + sgn(b_m);
                    end else begin
                        s_m  = acc_m - b_m;
                        ss_m = sgn(acc_m) - sgn(b_m);
                    end
                    if (ss_m > HALF - 1 || ss_m < -HALF) o_m = 1'b1;
                    if (s_m > MAXV) begin
                        c_m   = 1'b1;
                        acc_m = sat_en ? MAXV : s_m - (MAXV + 1);
                    end else if (s_m < 0) begin
                        c_m   = 1'b1;
                        acc_m = sat_en ? 0 : s_m + (MAXV + 1);
                    end else begin
                        acc_m = s_m;
                    end
                end
                q0.push_back('{acc_m, 1'b1, (k == NUM_OPS - 1), c_m, o_m});
            end
            cur0 = q0.pop_front();
        end else if (q0.size() > 0) begin
            cur0 = q0.pop_front();
        end else begin
            cur0.busy = 1'b0;
            cur0.done = 1'b0;
        end
    end

    // Reference model for the single-operand instance.
    always @(posedge clk) begin
        if (reset) begin
            cur1 = '{default: 0};
        end else if (!cur1.busy && start1) begin
            cur1 = '{int'(operands1), 1'b1, 1'b1, 1'b0, 1'b0};
        end else begin
            cur1.busy = 1'b0;
            cur1.done = 1'b0;
        end
    end

    // Per-cycle compare of both instances against their models.
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            chk("cyc_result", int'(result), cur0.res);
            chk("cyc_busy",   int'(busy),   int'(cur0.busy));
            chk("cyc_done",   int'(done),   int'(cur0.done));
            chk("cyc_carry",  int'(carry),  int'(cur0.carry));
            chk("cyc_ovf",    int'(ovf),    int'(cur0.ovf));
            chk("cyc1_result", int'(result1), cur1.res);
            chk("cyc1_busy",   int'(busy1),   int'(cur1.busy));
            chk("cyc1_done",   int'(done1),   int'(cur1.done));
            chk("cyc1_carry",  int'(carry1),  int'(cur1.carry));
            chk("cyc1_ovf",    int'(ovf1),    int'(cur1.ovf));
        end
    end

    // Run one sequence with literal expectations. glitch >= 0 pulses start
    // during that cycle of the sequence, and the pulse must be ignored.
    task automatic run_directed(input string name, input logic [NUM_OPS*WIDTH-1:0] ops,
                                input logic [NUM_OPS-1:0] mask, input logic sat,
                                input int er, input int ec, input int eo, input int glitch);
        int lat;
        @(negedge clk);
        operands = ops;
        op_mask  = mask;
        sat_en   = sat;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        operands = (NUM_OPS*WIDTH)'($urandom);
        op_mask  = NUM_OPS'($urandom);
        sat_en   = 1'($urandom);
        lat      = 0;
        while (!done && lat < 20) begin
            start = (lat == glitch);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({name, "_latency"}, lat, NUM_OPS - 1);
        chk({name, "_result"}, int'(result), er);
        chk({name, "_carry"}, int'(carry), ec);
        chk({name, "_ovf"}, int'(ovf), eo);
        chk({name, "_model"}, cur0.res, er);
        @(negedge clk);
        chk({name, "_done_drop"}, int'(done), 0);
        chk({name, "_busy_drop"}, int'(busy), 0);
        chk({name, "_hold"}, int'(result), er);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        operands  = '0;
        op_mask   = '0;
        sat_en    = 1'b0;
        start1    = 1'b0;
        operands1 = '0;
        op_mask1  = 1'b0;
        sat_en1   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", int'(result), 0);
        chk("rst_busy",   int'(busy),   0);
        chk("rst_done",   int'(done),   0);
        chk("rst_carry",  int'(carry),  0);
        chk("rst_ovf",    int'(ovf),    0);
        chk("rst1_busy",  int'(busy1),  0);
        reset    = 1'b0;
        check_en = 1'b1;

        run_directed("basic",     {8'd3, 8'd5, 8'd20, 8'd10},  4'b1010, 1'b0, 28,  0, 0, -1);
        run_directed("wrap",      {8'd0, 8'd0, 8'd100, 8'd200}, 4'b1110, 1'b0, 44,  1, 0, -1);
        run_directed("sat_add",   {8'd0, 8'd0, 8'd100, 8'd200}, 4'b1110, 1'b1, 255, 1, 0, -1);
        run_directed("sub_wrap",  {8'd0, 8'd0, 8'd10, 8'd5},    4'b0000, 1'b0, 251, 1, 0, -1);
        run_directed("sub_sat",   {8'd0, 8'd0, 8'd10, 8'd5},    4'b0000, 1'b1, 0,   1, 0, -1);
        run_directed("signed_ov", {8'd0, 8'd0, 8'd100, 8'd100}, 4'b1110, 1'b0, 200, 0, 1, -1);
        run_directed("ign_start", {8'd3, 8'd5, 8'd20, 8'd10},  4'b1010, 1'b0, 28,  0, 0, 1);

        // Reset in the middle of a sequence, after the carry flag has been set.
        @(negedge clk);
        operands = {8'd0, 8'd0, 8'd100, 8'd200};
        op_mask  = 4'b1110;
        sat_en   = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_carry_set", int'(carry), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_result", int'(result), 0);
        chk("midrst_busy",   int'(busy),   0);
        chk("midrst_done",   int'(done),   0);
        chk("midrst_carry",  int'(carry),  0);
        run_directed("after_rst", {8'd3, 8'd5, 8'd20, 8'd10}, 4'b1010, 1'b0, 28, 0, 0, -1);

        // Single-operand instance.
        @(negedge clk);
        operands1 = 8'd77;
        start1    = 1'b1;
        @(negedge clk);
        start1    = 1'b0;
        operands1 = 8'd5;
        chk("one_done",   int'(done1),   1);
        chk("one_result", int'(result1), 77);
        chk("one_carry",  int'(carry1),  0);
        chk("one_ovf",    int'(ovf1),    0);
        chk("one_model",  cur1.res,      77);
        @(negedge clk);
        chk("one_done_drop", int'(done1), 0);
        chk("one_busy_drop", int'(busy1), 0);

        // Randomized phase: random starts, operands, masks, saturation and rare resets.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 2) == 0);
            operands  = (NUM_OPS*WIDTH)'($urandom);
            op_mask   = NUM_OPS'($urandom);
            sat_en    = 1'($urandom);
            start1    = 1'($urandom);
            operands1 = WIDTH'($urandom);
            op_mask1  = 1'($urandom);
            sat_en1   = 1'($urandom);
            reset     = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        reset  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        repeat (8) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
